// File: rtl/fetch_issue.sv
// -----------------------------------------------------------------------------
// fetch_issue
//
// Instruction-fetch issue stage sitting right after the PC register. Issues an
// instruction-bus request for the current PC, captures the returned word into
// a registered fetch/decode output slot, and holds the PC register (fetch_busy)
// while a fetch is outstanding. On a redirect, a request already on the bus is
// kept alive until it completes, and its response is then thrown away.
//
// Ports
//   i_clk            clock
//   i_reset          asynchronous active-high reset
//   i_pc             current PC (stable while o_fetch_busy=1)
//   i_redirect       pipeline flush; PC register takes the target this edge
//   i_stall_d        decode is not accepting the output slot this cycle
//   o_ireq_valid     instruction-bus request valid
//   o_ireq_addr      instruction-bus request address
//   i_iresp_data_ok  response valid (completes a request seen with ireq_valid)
//   i_iresp_data     instruction word returned with i_iresp_data_ok
//   o_f_valid        output slot holds an instruction
//   o_f_pc           PC of the slot instruction
//   o_f_instr        slot instruction (0 when misaligned)
//   o_f_misalign     slot PC had pc[1:0] != 0
//   o_fetch_busy     stall request to the PC register
//
// State | meaning
// IDLE  | first cycle out of reset, no request yet
// REQ   | fetching i_pc (misaligned PCs complete without bus traffic)
// HOLD  | word fetched but slot blocked by decode; buffered in r_hold_*
// DROP  | redirected while a request was live; finish it and discard data
// -----------------------------------------------------------------------------
module fetch_issue #(
  parameter logic [63:0] PC_RESET = 64'h8000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [63:0] i_pc,
  input  logic        i_redirect,
  input  logic        i_stall_d,
  output logic        o_ireq_valid,
  output logic [63:0] o_ireq_addr,
  input  logic        i_iresp_data_ok,
  input  logic [31:0] i_iresp_data,
  output logic        o_f_valid,
  output logic [63:0] o_f_pc,
  output logic [31:0] o_f_instr,
  output logic        o_f_misalign,
  output logic        o_fetch_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [63:0] r_hold_pc;
  logic [31:0] r_hold_instr;
  logic        r_hold_mis;
  logic [63:0] r_drop_addr;

  logic        r_f_valid;
  logic [63:0] r_f_pc;
  logic [31:0] r_f_instr;
  logic        r_f_mis;

  logic        w_aligned;
  logic        w_complete;
  logic        w_slot_free;
  logic [31:0] w_fetch_instr;

  logic        w_load;
  logic [63:0] w_load_pc;
  logic [31:0] w_load_instr;
  logic        w_load_mis;
  logic        w_hold_wr;
  logic        w_drop_wr;

  assign w_aligned     = (i_pc[1:0] == 2'b00);
  // A misaligned PC completes immediately without touching the bus.
  assign w_complete    = w_aligned ? i_iresp_data_ok : 1'b1;
  assign w_slot_free   = !r_f_valid || !i_stall_d;
  assign w_fetch_instr = w_aligned ? i_iresp_data : 32'd0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_ireq_valid = 1'b0;
    o_ireq_addr  = i_pc;
    o_fetch_busy = 1'b1;
    w_load       = 1'b0;
    w_load_pc    = i_pc;
    w_load_instr = w_fetch_instr;
    w_load_mis   = !w_aligned;
    w_hold_wr    = 1'b0;
    w_drop_wr    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        o_ireq_addr = PC_RESET;
        w_state_nxt = S_REQ;
      end

      S_REQ: begin
        o_ireq_valid = w_aligned;
        o_ireq_addr  = i_pc;
        // PC may advance only when this fetch lands and is not being flushed.
        o_fetch_busy = !(w_complete && !i_redirect);
        if (i_redirect) begin
          if (!w_complete) begin
            w_state_nxt = S_DROP;
            w_drop_wr   = 1'b1;
          end
        end else if (w_complete) begin
          if (w_slot_free) begin
            w_load = 1'b1;
          end else begin
            w_hold_wr   = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        o_ireq_addr = r_hold_pc;
        if (i_redirect) begin
          w_state_nxt = S_REQ;
        end else if (!i_stall_d) begin
          w_load       = 1'b1;
          w_load_pc    = r_hold_pc;
          w_load_instr = r_hold_instr;
          w_load_mis   = r_hold_mis;
          w_state_nxt  = S_REQ;
        end
      end

      S_DROP: begin
        // Keep the orphaned request on the bus with its original address.
        o_ireq_valid = 1'b1;
        o_ireq_addr  = r_drop_addr;
        if (i_iresp_data_ok) begin
          w_state_nxt = S_REQ;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hold_pc    <= 64'd0;
      r_hold_instr <= 32'd0;
      r_hold_mis   <= 1'b0;
      r_drop_addr  <= 64'd0;
    end else begin
      if (w_hold_wr) begin
        r_hold_pc    <= i_pc;
        r_hold_instr <= w_fetch_instr;
        r_hold_mis   <= !w_aligned;
      end
      if (w_drop_wr) begin
        r_drop_addr <= i_pc;
      end
    end
  end

  // Output slot: a flush beats any load in the same cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_f_valid <= 1'b0;
      r_f_pc    <= 64'd0;
      r_f_instr <= 32'd0;
      r_f_mis   <= 1'b0;
    end else if (i_redirect) begin
      r_f_valid <= 1'b0;
    end else if (w_load) begin
      r_f_valid <= 1'b1;
      r_f_pc    <= w_load_pc;
      r_f_instr <= w_load_instr;
      r_f_mis   <= w_load_mis;
    end else if (!i_stall_d) begin
      r_f_valid <= 1'b0;
    end
  end

  assign o_f_valid    = r_f_valid;
  assign o_f_pc       = r_f_pc;
  assign o_f_instr    = r_f_instr;
  assign o_f_misalign = r_f_mis;

endmodule

// File: tb/tb_fetch_issue.sv
module tb_fetch_issue;

  localparam logic [63:0] B = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] i_pc;
  logic        i_redirect;
  logic        i_stall_d;
  logic        o_ireq_valid;
  logic [63:0] o_ireq_addr;
  logic        i_ok;
  logic [31:0] i_data;
  logic        o_f_valid;
  logic [63:0] o_f_pc;
  logic [31:0] o_f_instr;
  logic        o_f_misalign;
  logic        o_fetch_busy;

  int checks   = 0;
  int failures = 0;

  fetch_issue #(.PC_RESET(B)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_pc            (i_pc),
    .i_redirect      (i_redirect),
    .i_stall_d       (i_stall_d),
    .o_ireq_valid    (o_ireq_valid),
    .o_ireq_addr     (o_ireq_addr),
    .i_iresp_data_ok (i_ok),
    .i_iresp_data    (i_data),
    .o_f_valid       (o_f_valid),
    .o_f_pc          (o_f_pc),
    .o_f_instr       (o_f_instr),
    .o_f_misalign    (o_f_misalign),
    .o_fetch_busy    (o_fetch_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [63:0] pc;
    logic        redir;
    logic        stall;
    logic        ok;
    logic [31:0] data;
    logic        e_iv;
    logic [63:0] e_addr;
    logic        e_busy;
    logic        e_fv;
    logic [63:0] e_fpc;
    logic [31:0] e_instr;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [63:0] pc, logic redir, logic stall,
                              logic ok, logic [31:0] data, logic e_iv,
                              logic [63:0] e_addr, logic e_busy, logic e_fv,
                              logic [63:0] e_fpc, logic [31:0] e_instr, logic e_mis);
    vec_t v;
    v.rst = r; v.pc = pc; v.redir = redir; v.stall = stall; v.ok = ok; v.data = data;
    v.e_iv = e_iv; v.e_addr = e_addr; v.e_busy = e_busy; v.e_fv = e_fv;
    v.e_fpc = e_fpc; v.e_instr = e_instr; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [63:0] pc, input logic redir, input logic stall,
                       input logic ok, input logic [31:0] data);
    i_pc       = pc;
    i_redirect = redir;
    i_stall_d  = stall;
    i_ok       = ok;
    i_data     = data;
  endtask

  // Leaves reset released on a falling edge; the cycle that follows is IDLE.
  task automatic do_reset();
    rst = 1'b1;
    drive(B, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model of the fetch stage, kept as occupancy flags.
  bit          m_started;
  bit          m_zombie;
  logic [63:0] m_zaddr;
  bit          m_buf;
  logic [63:0] m_bpc;
  logic [31:0] m_binstr;
  bit          m_bmis;
  bit          m_sv;
  logic [63:0] m_spc;
  logic [31:0] m_sinstr;
  bit          m_smis;

  task automatic model_reset();
    m_started = 0; m_zombie = 0; m_zaddr = '0;
    m_buf = 0; m_bpc = '0; m_binstr = '0; m_bmis = 0;
    m_sv = 0; m_spc = '0; m_sinstr = '0; m_smis = 0;
  endtask

  task automatic model_step(input logic [63:0] pc, input bit redir, input bit stall,
                            input bit ok, input logic [31:0] data,
                            output bit e_iv, output logic [63:0] e_addr, output bit e_busy);
    bit          aligned;
    bit          done;
    bit          deliver;
    logic [63:0] d_pc;
    logic [31:0] d_instr;
    bit          d_mis;
    aligned = (pc % 4 == 0);
    done    = !aligned || ok;
    deliver = 0; d_pc = '0; d_instr = '0; d_mis = 0;
    e_iv = 0; e_addr = '0; e_busy = 1;
    if (!m_started) begin
      m_started = 1;
    end else if (m_zombie) begin
      e_iv = 1; e_addr = m_zaddr;
      if (ok) m_zombie = 0;
    end else if (m_buf) begin
      if (redir) m_buf = 0;
      else if (!stall) begin
        deliver = 1; d_pc = m_bpc; d_instr = m_binstr; d_mis = m_bmis; m_buf = 0;
      end
    end else begin
      e_iv = aligned; e_addr = pc;
      e_busy = !(done && !redir);
      if (redir) begin
        if (!done) begin m_zombie = 1; m_zaddr = pc; end
      end else if (done) begin
        if (!m_sv || !stall) begin
          deliver = 1; d_pc = pc; d_instr = aligned ? data : 32'd0; d_mis = !aligned;
        end else begin
          m_buf = 1; m_bpc = pc; m_binstr = aligned ? data : 32'd0; m_bmis = !aligned;
        end
      end
    end
    if (redir) m_sv = 0;
    else if (deliver) begin m_sv = 1; m_spc = d_pc; m_sinstr = d_instr; m_smis = d_mis; end
    else if (!stall) m_sv = 0;
  endtask

  initial begin
    rst = 1'b1;
    drive(B, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    chk("rst_iv", o_ireq_valid, 0);
    chk("rst_busy", o_fetch_busy, 1);
    chk("rst_fv", o_f_valid, 0);
    chk("rst_fpc", o_f_pc, 0);
    chk("rst_instr", o_f_instr, 0);
    chk("rst_mis", o_f_misalign, 0);

    // rst, pc, redir, stall, ok, data | iv, addr, busy, fv, fpc, instr, mis
    // Zero-wait sequential fetches from reset
    vecs.push_back(mk(1, B,      0,0,0, 32'h0,  0, 0,      1, 0, 0, 0, 0));
    vecs.push_back(mk(0, B,      0,0,1, 32'hA0, 1, B,      0, 0, 0, 0, 0));
    vecs.push_back(mk(0, B+4,    0,0,1, 32'hA1, 1, B+4,    0, 1, B,    32'hA0, 0));
    vecs.push_back(mk(0, B+8,    0,0,1, 32'hA2, 1, B+8,    0, 1, B+4,  32'hA1, 0));
    vecs.push_back(mk(0, B+12,   0,0,1, 32'hA3, 1, B+12,   0, 1, B+8,  32'hA2, 0));
    vecs.push_back(mk(0, B+16,   0,0,0, 32'h0,  1, B+16,   1, 1, B+12, 32'hA3, 0));
    // 3-cycle bus latency
    vecs.push_back(mk(1, B,      0,0,0, 32'h0,  0, 0,      1, 0, 0, 0, 0));
    vecs.push_back(mk(0, B,      0,0,0, 32'h0,  1, B,      1, 0, 0, 0, 0));
    vecs.push_back(mk(0, B,      0,0,0, 32'h0,  1, B,      1, 0, 0, 0, 0));
    vecs.push_back(mk(0, B,      0,0,1, 32'h13, 1, B,      0, 0, 0, 0, 0));
    vecs.push_back(mk(0, B+4,    0,0,0, 32'h0,  1, B+4,    1, 1, B, 32'h13, 0));
    // Decode stall while the next word returns
    vecs.push_back(mk(1, B,      0,0,0, 32'h0,  0, 0,      1, 0, 0, 0, 0));
    vecs.push_back(mk(0, B,      0,0,1, 32'hAA, 1, B,      0, 0, 0, 0, 0));
    vecs.push_back(mk(0, B+4,    0,1,1, 32'h00100093, 1, B+4, 0, 1, B, 32'hAA, 0));
    vecs.push_back(mk(0, B+8,    0,1,1, 32'h55, 0, 0,      1, 1, B, 32'hAA, 0));
    vecs.push_back(mk(0, B+8,    0,1,0, 32'h0,  0, 0,      1, 1, B, 32'hAA, 0));
    vecs.push_back(mk(0, B+8,    0,0,0, 32'h0,  0, 0,      1, 1, B, 32'hAA, 0));
    vecs.push_back(mk(0, B+8,    0,0,0, 32'h0,  1, B+8,    1, 1, B+4, 32'h00100093, 0));
    vecs.push_back(mk(0, B+8,    0,0,0, 32'h0,  1, B+8,    1, 0, 0, 0, 0));
    // Redirect with a live request, then redirect on a completing cycle
    vecs.push_back(mk(1, B+16,   0,0,0, 32'h0,  0, 0,      1, 0, 0, 0, 0));
    vecs.push_back(mk(0, B+16,   1,0,0, 32'h0,  1, B+16,   1, 0, 0, 0, 0));
    vecs.push_back(mk(0, B+256,  0,0,0, 32'h0,  1, B+16,   1, 0, 0, 0, 0));
    vecs.push_back(mk(0, B+256,  0,0,1, 32'hDEAD, 1, B+16, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, B+256,  1,0,1, 32'hBEEF, 1, B+256, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, B+512,  0,0,1, 32'hCAFE, 1, B+512, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, B+516,  0,0,0, 32'h0,  1, B+516,  1, 1, B+512, 32'hCAFE, 0));
    // Misaligned PC
    vecs.push_back(mk(1, B+2,    0,0,0, 32'h0,  0, 0,      1, 0, 0, 0, 0));
    vecs.push_back(mk(0, B+2,    0,0,1, 32'h12345678, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, B+6,    0,0,0, 32'h0,  0, 0,      0, 1, B+2, 32'h0, 1));
    vecs.push_back(mk(0, B+8,    0,0,0, 32'h0,  1, B+8,    1, 1, B+6, 32'h0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      drive(vecs[i].pc, vecs[i].redir, vecs[i].stall, vecs[i].ok, vecs[i].data);
      #1;
      chk($sformatf("v%0d_iv", i), o_ireq_valid, vecs[i].e_iv);
      if (vecs[i].e_iv) chk($sformatf("v%0d_addr", i), o_ireq_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_busy", i), o_fetch_busy, vecs[i].e_busy);
      chk($sformatf("v%0d_fv", i), o_f_valid, vecs[i].e_fv);
      if (vecs[i].e_fv || vecs[i].rst) begin
        chk($sformatf("v%0d_fpc", i), o_f_pc, vecs[i].e_fpc);
        chk($sformatf("v%0d_instr", i), o_f_instr, vecs[i].e_instr);
        chk($sformatf("v%0d_mis", i), o_f_misalign, vecs[i].e_mis);
      end
      @(negedge clk);
    end

    // Asynchronous reset while draining a redirected request
    do_reset();
    drive(B, 0, 0, 0, 32'h0);
    @(negedge clk);
    drive(B, 0, 0, 1, 32'h1111_1111);
    @(negedge clk);
    drive(B+4, 1, 0, 0, 32'h0);
    #1;
    chk("drop_pre_fv", o_f_valid, 1);
    chk("drop_pre_fpc", o_f_pc, B);
    @(negedge clk);
    drive(B+64'h200, 0, 0, 0, 32'h0);
    #1;
    chk("drop_iv", o_ireq_valid, 1);
    chk("drop_addr", o_ireq_addr, B+4);
    chk("drop_busy", o_fetch_busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_iv", o_ireq_valid, 0);
    chk("arst_busy", o_fetch_busy, 1);
    chk("arst_fv", o_f_valid, 0);
    chk("arst_fpc", o_f_pc, 0);
    chk("arst_instr", o_f_instr, 0);
    chk("arst_mis", o_f_misalign, 0);
    @(negedge clk);
    drive(B, 0, 0, 1, 32'h9999_9999);
    @(negedge clk);
    rst = 1'b0;
    drive(B, 0, 0, 1, 32'h9999_9999);
    #1;
    chk("arst_idle_iv", o_ireq_valid, 0);
    chk("arst_idle_fv", o_f_valid, 0);
    @(negedge clk);
    drive(B, 0, 0, 1, 32'h2222_2222);
    #1;
    chk("arst_req_iv", o_ireq_valid, 1);
    chk("arst_req_addr", o_ireq_addr, B);
    chk("arst_req_busy", o_fetch_busy, 0);
    chk("arst_req_fv", o_f_valid, 0);
    @(negedge clk);
    drive(B+4, 0, 0, 0, 32'h0);
    #1;
    chk("arst_out_fv", o_f_valid, 1);
    chk("arst_out_fpc", o_f_pc, B);
    chk("arst_out_instr", o_f_instr, 32'h2222_2222);
    @(negedge clk);

    // Random traffic against the model, with a bench-side PC register
    begin
      logic [63:0] pc_q;
      bit          redir, stall, ok;
      logic [31:0] data;
      bit          e_iv, e_busy;
      logic [63:0] e_addr;
      do_reset();
      model_reset();
      pc_q = B;
      for (int c = 0; c < 3000; c++) begin
        redir = ($urandom % 8) == 0;
        stall = ($urandom % 4) == 0;
        ok    = ($urandom % 3) != 0;
        data  = $urandom;
        drive(pc_q, redir, stall, ok, data);
        #1;
        chk("rnd_fv", o_f_valid, m_sv);
        if (m_sv) begin
          chk("rnd_fpc", o_f_pc, m_spc);
          chk("rnd_instr", o_f_instr, m_sinstr);
          chk("rnd_mis", o_f_misalign, m_smis);
        end
        model_step(pc_q, redir, stall, ok, data, e_iv, e_addr, e_busy);
        chk("rnd_iv", o_ireq_valid, e_iv);
        if (e_iv) chk("rnd_addr", o_ireq_addr, e_addr);
        chk("rnd_busy", o_fetch_busy, e_busy);
        if (redir) begin
          pc_q = B + 64'(($urandom % 256) * 4);
          if (($urandom % 8) == 0) pc_q = pc_q + 2;
        end else if (!e_busy) begin
          pc_q = pc_q + 4;
        end
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
